alu_program_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 8-bit register-file + ALU datapath. Fetches 16-bit instruction words from an external instruction memory over a req/ack handshake, then drives register addresses, ALU opcode, write-back enable and write-back source select. Handles IN/OUT port traffic and stops on HALT. Replaces the free-running per-clock decoder with a sequenced, restartable program flow.

---
 rtl/alu_program_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_program_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_program_sequencer.sv
// alu_program_sequencer
// Fetch/decode/execute controller for the 8-bit register-file + ALU datapath.
// Instructions are fetched one at a time from an external memory. Each one is
// decoded into register addresses, an ALU opcode and write-back controls, and
// then executed in a single cycle. The sequencer stops on HALT and can be
// restarted from address 0.
//
// Fetch handshake: imem_req rises on entry to FETCH. It stays high, with
// imem_addr held stable, up to and including the cycle in which imem_ack is
// sampled high. The word on imem_data in that cycle is the instruction. An
// imem_ack seen in any other cycle is ignored.
module alu_program_sequencer #(
  parameter int         PC_W   = 8,
  parameter logic [7:0] MAX_OP = 8'h14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [2:0]      reg_addr_a,
  output logic [2:0]      reg_addr_b,
  output logic [7:0]      alu_opcode,
  output logic            write_enable,
  output logic            wb_sel,
  input  logic [7:0]      in_port,
  output logic [7:0]      out_port,
  output logic            out_valid,
  input  logic [7:0]      reg_a_data,
  output logic            busy,
  output logic            halted,
  output logic [2:0]      dbg_state,
  output logic [15:0]     dbg_ir,
  output logic [7:0]      dbg_in_sample
);

  localparam logic [7:0] OP_WB_LO = 8'h0C;
  localparam logic [7:0] OP_WB_HI = 8'h10;
  localparam logic [7:0] OP_IN    = 8'h11;
  localparam logic [7:0] OP_OUT   = 8'h12;
  localparam logic [7:0] OP_HALT  = 8'h13;
  localparam logic [7:0] OP_WB_X  = 8'h14;
  localparam logic [7:0] OP_NOP   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [7:0]      r_out_port;
  logic            r_out_valid;
  logic [7:0]      r_in_sample;

  logic [7:0]      w_op;
  logic            w_exec;
  logic            w_is_wb;
  logic            w_is_in;
  logic            w_is_out;
  logic            w_is_halt;
  logic            w_restart;

  // The opcode field is decoded from the instruction register. Anything past
  // the highest defined opcode becomes a NOP. The reset value of the register
  // decodes to NOP with both register addresses at 0.
  assign w_op      = (r_ir[15:8] > MAX_OP) ? OP_NOP : r_ir[15:8];
  assign w_exec    = (r_state == S_EXECUTE);
  assign w_is_wb   = ((w_op >= OP_WB_LO) && (w_op <= OP_WB_HI)) || (w_op == OP_WB_X);
  assign w_is_in   = (w_op == OP_IN);
  assign w_is_out  = (w_op == OP_OUT);
  assign w_is_halt = (w_op == OP_HALT);
  assign w_restart = ((r_state == S_IDLE) || (r_state == S_HALTED)) && start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; start is only looked at when not busy
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH:   if (imem_ack) w_next = S_DECODE;
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: w_next = w_is_halt ? S_HALTED : S_FETCH;
      S_HALTED:  if (start) w_next = S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  // Program counter: cleared on (re)start; steps after every non-HALT instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_pc <= '0;
    else if (w_restart)             r_pc <= '0;
    else if (w_exec && !w_is_halt)  r_pc <= r_pc + PC_W'(1);
  end

  // Instruction register: captures the fetched word on the accepted ack only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_ir <= {OP_NOP, 8'h00};
    else if ((r_state == S_FETCH) && imem_ack) r_ir <= imem_data;
  end

  // OUT copies reg A to the port with a one-cycle strobe; IN's input is traced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_port  <= 8'h00;
      r_out_valid <= 1'b0;
      r_in_sample <= 8'h00;
    end else begin
      r_out_valid <= w_exec && w_is_out;
      if (w_exec && w_is_out) r_out_port  <= reg_a_data;
      if (w_exec && w_is_in)  r_in_sample <= in_port;
    end
  end

  assign imem_req      = (r_state == S_FETCH);
  assign imem_addr     = r_pc;
  assign reg_addr_a    = r_ir[7:5];
  assign reg_addr_b    = r_ir[4:2];
  assign alu_opcode    = w_op;
  assign write_enable  = w_exec && (w_is_wb || w_is_in);
  assign wb_sel        = w_exec && w_is_in;
  assign out_port      = r_out_port;
  assign out_valid     = r_out_valid;
  assign busy          = (r_state == S_FETCH) || (r_state == S_DECODE) || w_exec;
  assign halted        = (r_state == S_HALTED);
  assign dbg_state     = r_state;
  assign dbg_ir        = r_ir;
  assign dbg_in_sample = r_in_sample;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Bench for alu_program_sequencer: instruction memory responder, register-file
// stand-in, instruction-level reference model and a per-cycle compare process.
module tb_alu_program_sequencer;
  localparam int PC_W   = 8;
  localparam int BUDGET = 5000;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            imem_ack = 1'b0;
  logic [15:0]     imem_data = 16'h0000;
  logic [7:0]      in_port = 8'h00;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [2:0]      reg_addr_a, reg_addr_b;
  logic [7:0]      alu_opcode;
  logic            write_enable, wb_sel;
  logic [7:0]      out_port;
  logic            out_valid;
  logic [7:0]      reg_a_data;
  logic            busy, halted;
  logic [2:0]      dbg_state;
  logic [15:0]     dbg_ir;
  logic [7:0]      dbg_in_sample;

  always #5 clk = ~clk;

  alu_program_sequencer #(.PC_W(PC_W), .MAX_OP(8'h14)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .reg_addr_a(reg_addr_a), .reg_addr_b(reg_addr_b), .alu_opcode(alu_opcode),
    .write_enable(write_enable), .wb_sel(wb_sel), .in_port(in_port),
    .out_port(out_port), .out_valid(out_valid), .reg_a_data(reg_a_data),
    .busy(busy), .halted(halted), .dbg_state(dbg_state), .dbg_ir(dbg_ir),
    .dbg_in_sample(dbg_in_sample)
  );

  // ---------------- environment state ----------------
  typedef struct {
    logic [7:0] addr;
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] op;
    logic       we;
    logic       wb;
    logic       is_out;
    logic       is_halt;
    logic [7:0] out_val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [15:0] mem [256];
  logic [7:0]  regs [8];
  logic [7:0]  m_final [8];
  int n_checks = 0;
  int n_pass = 0;
  int cmp_phase = 0;
  int we_cnt = 0;
  int ov_cnt = 0;
  int dly_min = 0;
  int dly_max = 0;
  bit spur_en = 1'b0;

  // Register file stand-in; an ALU result is modelled as opcode ^ 8'h5A
  assign reg_a_data = regs[reg_addr_a];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (write_enable) begin
      regs[reg_addr_a] <= wb_sel ? in_port : (alu_opcode ^ 8'h5A);
    end
  end

  // Pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable) we_cnt <= we_cnt + 1;
      if (out_valid)    ov_cnt <= ov_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic void build_model(input int max_instr);
    logic [7:0]  mr [8];
    logic [15:0] w;
    logic [7:0]  raw;
    exp_t        e;
    int          pc;
    for (int i = 0; i < 8; i++) mr[i] = regs[i];
    pc = 0;
    for (int i = 0; i < max_instr; i++) begin
      w         = mem[pc];
      raw       = w[15:8];
      e.addr    = 8'(pc);
      e.op      = (raw > 8'h14) ? 8'hFF : raw;
      e.a       = w[7:5];
      e.b       = w[4:2];
      e.wb      = (e.op == 8'h11);
      e.we      = ((e.op >= 8'h0C) && (e.op <= 8'h10)) || (e.op == 8'h14) || e.wb;
      e.is_out  = (e.op == 8'h12);
      e.is_halt = (e.op == 8'h13);
      e.out_val = mr[e.a];
      exp_q.push_back(e);
      if (e.we) mr[e.a] = e.wb ? in_port : (e.op ^ 8'h5A);
      if (e.is_halt) break;
      pc = (pc + 1) % 256;
    end
    for (int i = 0; i < 8; i++) m_final[i] = mr[i];
  endfunction

  // ---------------- instruction memory responder ----------------
  initial begin
    int wait_cnt;
    bit was_req;
    wait_cnt = 0;
    was_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        imem_ack = 1'b0;
        was_req = 1'b0;
      end else if (imem_req) begin
        if (!was_req) begin
          wait_cnt = $urandom_range(dly_max, dly_min);
          was_req = 1'b1;
        end
        if (wait_cnt == 0 && exp_q.size() > 0) begin
          imem_ack = 1'b1;
          imem_data = mem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          imem_data = 16'($urandom);
          if (wait_cnt > 0) wait_cnt--;
        end
      end else begin
        was_req = 1'b0;
        imem_ack = spur_en && ($urandom_range(1, 0) == 1);
        imem_data = 16'($urandom);
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  initial begin
    bit         prev_wait;
    bit         out_slot;
    logic [7:0] prev_addr;
    logic [7:0] nxt;
    prev_wait = 1'b0;
    prev_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        cmp_phase = 0;
        prev_wait = 1'b0;
      end else if (cmp_phase == 1) begin
        check("dec_req_low", 32'(imem_req), 0);
        check("dec_busy", 32'(busy), 1);
        check("dec_reg_a", 32'(reg_addr_a), 32'(cur.a));
        check("dec_reg_b", 32'(reg_addr_b), 32'(cur.b));
        check("dec_opcode", 32'(alu_opcode), 32'(cur.op));
        check("dec_we_low", 32'(write_enable), 0);
        check("dec_out_valid", 32'(out_valid), 0);
        cmp_phase = 2;
      end else if (cmp_phase == 2) begin
        check("exe_we", 32'(write_enable), 32'(cur.we));
        if (cur.we) check("exe_wb_sel", 32'(wb_sel), 32'(cur.wb));
        check("exe_opcode", 32'(alu_opcode), 32'(cur.op));
        check("exe_reg_a", 32'(reg_addr_a), 32'(cur.a));
        check("exe_req_low", 32'(imem_req), 0);
        check("exe_busy", 32'(busy), 1);
        check("exe_out_valid", 32'(out_valid), 0);
        cmp_phase = 3;
      end else begin
        out_slot = 1'b0;
        if (cmp_phase == 3) begin
          if (cur.is_halt) begin
            check("halt_flag", 32'(halted), 1);
            check("halt_busy", 32'(busy), 0);
            check("halt_opcode", 32'(alu_opcode), 32'h13);
            check("halt_pc", 32'(imem_addr), 32'(cur.addr));
            check("halt_req", 32'(imem_req), 0);
          end else begin
            nxt = cur.addr + 8'd1;
            check("next_req_latency", 32'(imem_req), 1);
            check("next_addr", 32'(imem_addr), 32'(nxt));
          end
          check("out_valid_pulse", 32'(out_valid), 32'(cur.is_out));
          if (cur.is_out) check("out_port", 32'(out_port), 32'(cur.out_val));
          out_slot = 1'b1;
          cmp_phase = 0;
        end
        if (!out_slot) check("out_valid_idle", 32'(out_valid), 0);
        check("we_outside_exec", 32'(write_enable), 0);
        if (prev_wait) begin
          check("req_held", 32'(imem_req), 1);
          check("addr_held", 32'(imem_addr), 32'(prev_addr));
        end
        if (imem_req && imem_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_fetch: fetch at addr %0h, want no fetch", imem_addr);
          end else begin
            cur = exp_q.pop_front();
            check("fetch_addr", 32'(imem_addr), 32'(cur.addr));
            cmp_phase = 1;
          end
          prev_wait = 1'b0;
        end else begin
          prev_wait = imem_req;
          prev_addr = imem_addr;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_prog(input int max_instr, input int hold, input string tag,
                          output int we_d, output int ov_d);
    int we0, ov0, cyc;
    build_model(max_instr);
    we0 = we_cnt;
    ov0 = ov_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!(exp_q.size() == 0 && cmp_phase == 0) && cyc < BUDGET) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (cyc >= BUDGET) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d instructions outstanding after %0d cycles, want 0",
               tag, exp_q.size(), cyc);
      exp_q.delete();
    end
    for (int i = 0; i < 8; i++) check({tag, "_regfile"}, 32'(regs[i]), 32'(m_final[i]));
    we_d = we_cnt - we0;
    ov_d = ov_cnt - ov0;
  endtask

  task automatic gen_random();
    int n, cat, v;
    logic [7:0] op;
    n = $urandom_range(12, 3);
    for (int i = 0; i < n; i++) begin
      cat = $urandom_range(4, 0);
      v = $urandom_range(5, 0);
      case (cat)
        0:       op = 8'($urandom_range(11, 0));
        1:       op = (v == 5) ? 8'h14 : (8'h0C + 8'(v));
        2:       op = 8'h11;
        3:       op = 8'h12;
        default: op = 8'($urandom_range(255, 21));
      endcase
      mem[i] = {op, 8'($urandom)};
    end
    mem[n] = {8'h13, 8'($urandom)};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int we_d, ov_d;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFF00;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_reg_a", 32'(reg_addr_a), 0);
    check("rst_reg_b", 32'(reg_addr_b), 0);
    check("rst_opcode", 32'(alu_opcode), 32'hFF);
    check("rst_we", 32'(write_enable), 0);
    check("rst_wb_sel", 32'(wb_sel), 0);
    check("rst_out_port", 32'(out_port), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);

    // write-back op then HALT, ack one cycle after req
    mem[0] = 16'h0C24; mem[1] = 16'h1300;
    dly_min = 1; dly_max = 1; spur_en = 1'b0;
    run_prog(16, 2, "basic", we_d, ov_d);
    check("basic_halted", 32'(halted), 1);
    check("basic_pc", 32'(imem_addr), 1);
    check("basic_we_pulses", 32'(we_d), 1);
    check("basic_reg1", 32'(regs[1]), 32'h56);

    // IN into r2, restarted from HALTED
    mem[0] = 16'h1140; mem[1] = 16'h1300;
    in_port = 8'hA5;
    run_prog(16, 1, "in", we_d, ov_d);
    check("in_reg2", 32'(regs[2]), 32'hA5);
    check("in_we_pulses", 32'(we_d), 1);
    check("in_sample", 32'(dbg_in_sample), 32'hA5);
    check("in_pc", 32'(imem_addr), 1);

    // IN 8'h3C into r1, then OUT r1
    mem[0] = 16'h1120; mem[1] = 16'h1220; mem[2] = 16'h1300;
    in_port = 8'h3C;
    run_prog(16, 3, "out", we_d, ov_d);
    check("out_value", 32'(out_port), 32'h3C);
    check("out_pulses", 32'(ov_d), 1);
    check("out_we_pulses", 32'(we_d), 1);

    // slow memory with spurious acks; undefined opcode 0x20
    mem[0] = 16'h2000; mem[1] = 16'h0D48; mem[2] = 16'h1300;
    dly_min = 5; dly_max = 5; spur_en = 1'b1;
    run_prog(16, 1, "slow", we_d, ov_d);
    check("slow_pc", 32'(imem_addr), 2);
    check("slow_we_pulses", 32'(we_d), 1);
    check("slow_reg2", 32'(regs[2]), 32'h57);

    // randomized programs
    for (int k = 0; k < 10; k++) begin
      gen_random();
      in_port = 8'($urandom);
      dly_min = 0; dly_max = 3;
      run_prog(64, $urandom_range(3, 1), "rand", we_d, ov_d);
      check("rand_halted", 32'(halted), 1);
    end

    // NOP sweep across the whole address space; pc wraps 255 -> 0
    for (int i = 0; i < 256; i++) mem[i] = {8'($urandom_range(255, 21)), 8'($urandom)};
    dly_min = 0; dly_max = 1;
    run_prog(258, 1, "wrap", we_d, ov_d);
    repeat (2) @(negedge clk);
    check("wrap_wait_req", 32'(imem_req), 1);
    check("wrap_wait_addr", 32'(imem_addr), 2);
    check("wrap_we_pulses", 32'(we_d), 0);

    // asynchronous reset while a fetch is pending
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 0);
    check("arst_addr", 32'(imem_addr), 0);
    check("arst_busy", 32'(busy), 0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_idle_busy", 32'(busy), 0);
    check("arst_idle_halted", 32'(halted), 0);
    check("arst_idle_req", 32'(imem_req), 0);
    check("arst_opcode", 32'(alu_opcode), 32'hFF);

    // restart from IDLE after reset fetches address 0 again
    mem[0] = 16'h0C24; mem[1] = 16'h1300;
    run_prog(16, 1, "restart", we_d, ov_d);
    check("restart_pc", 32'(imem_addr), 1);
    check("restart_halted", 32'(halted), 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
